// File: rtl/snake_pkg.sv
// Shared types for the snake game: heading encoding and the reversal helper.
// The game core imports this same package so both sides agree on the encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Encoding pairs opposites so that flipping bit 0 gives the reverse heading.
  function automatic dir_t opposite(input dir_t dir);
    return dir_t'(dir ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// One push-button: 2-flop synchroniser, stability counter and registered rise pulse.
// DEBOUNCE_CYCLES must be at least 2.
module snake_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    rise_d = level_d & ~level_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/snake_dir_input.sv
// Direction front end: four debounced buttons, priority capture of the newest
// press, and a step-gated commit of the heading that refuses 180-degree turns.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_step,
  output logic [1:0] o_dir,
  output logic       o_pending,
  output logic       o_press,
  output logic       o_rejected
);

  // Bit 3 = UP ... bit 0 = RIGHT, so the priority order reads top-down.
  logic [3:0] btn_raw;
  logic [3:0] btn_rise;
  logic [3:0] btn_level_unused;

  assign btn_raw = {i_up, i_down, i_left, i_right};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    snake_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_raw  (btn_raw[g]),
      .o_level(btn_level_unused[g]),
      .o_rise (btn_rise[g])
    );
  end

  dir_t press_dir;
  logic any_rise;

  always_comb begin
    any_rise = |btn_rise;
    if (btn_rise[3])      press_dir = DIR_UP;
    else if (btn_rise[2]) press_dir = DIR_DOWN;
    else if (btn_rise[1]) press_dir = DIR_LEFT;
    else                  press_dir = DIR_RIGHT;
  end

  dir_t dir_q, dir_d;
  dir_t pending_dir_q, pending_dir_d;
  logic pending_q, pending_d;
  logic press_q, press_d;
  logic rejected_q, rejected_d;

  always_comb begin
    dir_d         = dir_q;
    pending_d     = pending_q;
    pending_dir_d = pending_dir_q;
    press_d       = any_rise;
    rejected_d    = 1'b0;

    // Commit sees the request held before this cycle; a press arriving now
    // is stored afterwards and waits for the next step.
    if (i_step && pending_q) begin
      pending_d = 1'b0;
      if (pending_dir_q == opposite(dir_q)) begin
        rejected_d = 1'b1;
      end else begin
        dir_d = pending_dir_q;
      end
    end

    if (any_rise) begin
      pending_d     = 1'b1;
      pending_dir_d = press_dir;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      dir_q         <= DIR_RESET;
      pending_dir_q <= DIR_RESET;
      pending_q     <= 1'b0;
      press_q       <= 1'b0;
      rejected_q    <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      pending_dir_q <= pending_dir_d;
      pending_q     <= pending_d;
      press_q       <= press_d;
      rejected_q    <= rejected_d;
    end
  end

  assign o_dir      = dir_q;
  assign o_pending  = pending_q;
  assign o_press    = press_q;
  assign o_rejected = rejected_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Self-checking bench for snake_dir_input with DEBOUNCE_CYCLES=4: a table of
// press/step vectors plus hand-written reset and same-cycle sequences.
module tb_snake_dir_input;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst;
  logic       i_up, i_down, i_left, i_right, i_step;
  logic [1:0] o_dir;
  logic       o_pending, o_press, o_rejected;

  snake_dir_input #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_up      (i_up),
    .i_down    (i_down),
    .i_left    (i_left),
    .i_right   (i_right),
    .i_step    (i_step),
    .o_dir     (o_dir),
    .o_pending (o_pending),
    .o_press   (o_press),
    .o_rejected(o_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: expectations keyed by the clock edge after which they hold.
  typedef enum {S_DIR, S_PEND, S_PRESS, S_REJ} sig_t;
  typedef struct {
    int         due;
    sig_t       sig;
    logic [1:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int due, input sig_t sig, input logic [1:0] val, input string nm);
    exp_t e;
    e.due = due; e.sig = sig; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sig)
          S_DIR:   check({sb[i].name, ".o_dir"},      32'(o_dir),      32'(sb[i].val));
          S_PEND:  check({sb[i].name, ".o_pending"},  32'(o_pending),  32'(sb[i].val));
          S_PRESS: check({sb[i].name, ".o_press"},    32'(o_press),    32'(sb[i].val));
          default: check({sb[i].name, ".o_rejected"}, 32'(o_rejected), 32'(sb[i].val));
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic drive_buttons(input logic [3:0] mask);
    {i_up, i_down, i_left, i_right} = mask;
  endtask

  // Press (mask of simultaneous raw rises), then release; press pulse lands
  // on the 7th edge after the raw change (2 sync + DB stable + 1 register).
  task automatic press(input logic [3:0] mask, input string nm);
    int c;
    @(negedge clk);
    drive_buttons(mask);
    c = cyc;
    expect_at(c + 6, S_PRESS, 2'd0, {nm, ".early"});
    expect_at(c + 7, S_PRESS, 2'd1, {nm, ".pulse"});
    expect_at(c + 7, S_PEND,  2'd1, {nm, ".held"});
    expect_at(c + 8, S_PRESS, 2'd0, {nm, ".one_cycle"});
    repeat (8) @(negedge clk);
    drive_buttons(4'b0000);
    c = cyc;
    expect_at(c + 7, S_PRESS, 2'd0, {nm, ".release"});
    repeat (8) @(negedge clk);
  endtask

  task automatic step(input logic [1:0] d, input logic r, input string nm);
    int c;
    @(negedge clk);
    i_step = 1'b1;
    c = cyc;
    expect_at(c + 1, S_DIR,  d,      {nm, ".step"});
    expect_at(c + 1, S_PEND, 2'd0,   {nm, ".step"});
    expect_at(c + 1, S_REJ,  {1'b0, r}, {nm, ".step"});
    @(negedge clk);
    i_step = 1'b0;
    expect_at(c + 2, S_REJ, 2'd0, {nm, ".rej_once"});
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".o_dir"},      32'(o_dir),      32'd3);
    check({nm, ".o_pending"},  32'(o_pending),  32'd0);
    check({nm, ".o_press"},    32'(o_press),    32'd0);
    check({nm, ".o_rejected"}, 32'(o_rejected), 32'd0);
  endtask

  typedef struct {
    logic [3:0] mask;   // {up, down, left, right}
    logic [1:0] dir;    // heading expected after the step
    logic       rej;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    vecs[0]  = '{4'b1000, 2'd0, 1'b0, "v_up"};
    vecs[1]  = '{4'b0100, 2'd0, 1'b1, "v_down_reverse"};
    vecs[2]  = '{4'b0001, 2'd3, 1'b0, "v_right"};
    vecs[3]  = '{4'b0010, 2'd3, 1'b1, "v_left_reverse"};
    vecs[4]  = '{4'b1000, 2'd0, 1'b0, "v_up2"};
    vecs[5]  = '{4'b1000, 2'd0, 1'b0, "v_up_same"};
    vecs[6]  = '{4'b0010, 2'd2, 1'b0, "v_left"};
    vecs[7]  = '{4'b0001, 2'd2, 1'b1, "v_right_reverse"};
    vecs[8]  = '{4'b0100, 2'd1, 1'b0, "v_down"};
    vecs[9]  = '{4'b0110, 2'd1, 1'b0, "v_prio_down_left"};
    vecs[10] = '{4'b0011, 2'd2, 1'b0, "v_prio_left_right"};
    vecs[11] = '{4'b1111, 2'd0, 1'b0, "v_prio_all"};
    vecs[12] = '{4'b0000, 2'd0, 1'b0, "v_step_idle"};

    // Reset asserted mid-cycle, with UP held through release.
    rst = 1'b0;
    i_step = 1'b0;
    drive_buttons(4'b1000);
    #12 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(negedge clk);
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    expect_at(c + 6, S_PRESS, 2'd0, "reset_release.early");
    expect_at(c + 7, S_PRESS, 2'd1, "reset_release.pulse");
    expect_at(c + 7, S_PEND,  2'd1, "reset_release.held");
    repeat (8) @(negedge clk);
    drive_buttons(4'b0000);
    repeat (8) @(negedge clk);

    // A 3-cycle glitch must not produce a press.
    @(negedge clk);
    i_up = 1'b1;
    c = cyc;
    for (int k = 1; k <= 10; k++) expect_at(c + k, S_PRESS, 2'd0, "glitch");
    repeat (3) @(negedge clk);
    i_up = 1'b0;
    repeat (10) @(negedge clk);
    press(4'b1000, "hold_up");

    foreach (vecs[i]) begin
      if (vecs[i].mask != 4'b0000) press(vecs[i].mask, vecs[i].name);
      step(vecs[i].dir, vecs[i].rej, vecs[i].name);
    end

    // Newest wins: LEFT then DOWN before a step, from RIGHT.
    press(4'b0001, "nw_right");
    step(2'd3, 1'b0, "nw_right");
    press(4'b0010, "nw_left");
    press(4'b0100, "nw_down");
    step(2'd1, 1'b0, "newest_wins");

    // Step coinciding with a DOWN press event while UP is pending, heading LEFT.
    press(4'b0010, "sc_left");
    step(2'd2, 1'b0, "sc_left");
    press(4'b1000, "sc_up");
    @(negedge clk);
    i_down = 1'b1;
    c = cyc;
    repeat (6) @(negedge clk);
    i_step = 1'b1;
    expect_at(c + 7, S_DIR,   2'd0, "same_cycle");
    expect_at(c + 7, S_PEND,  2'd1, "same_cycle");
    expect_at(c + 7, S_PRESS, 2'd1, "same_cycle");
    expect_at(c + 7, S_REJ,   2'd0, "same_cycle");
    @(negedge clk);
    i_step = 1'b0;
    repeat (2) @(negedge clk);
    i_down = 1'b0;
    repeat (9) @(negedge clk);
    step(2'd0, 1'b1, "same_cycle_next");

    // Reset with UP pending and LEFT's counter at 2 discards everything.
    press(4'b1000, "rst_up");
    drain();
    @(negedge clk);
    i_left = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    i_left = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    check_reset_outputs("reset_mid_held");
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    for (int k = 1; k <= 8; k++) expect_at(c + k, S_PRESS, 2'd0, "reset_mid_nopress");
    repeat (9) @(negedge clk);
    step(2'd3, 1'b0, "reset_mid_step");

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
